cache_axi_txn_limiter: RTL

Sits between the cache subsystem's single AXI master port (I$, D$ and bypass traffic already merged) and the SoC interconnect. It counts outstanding read and write transactions and stalls new AR/AW requests when a count reaches its programmed limit. It also provides a quiesce handshake so the core can drain all memory traffic before a fence, reset-domain crossing or power-down. All channels pass through combinationally with zero added latency; only AR/AW valid/ready are gated.

---
 rtl/cache_axi_txn_limiter_pkg.sv | 58 +++++
 rtl/cache_axi_txn_limiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/cache_axi_txn_limiter_pkg.sv
// Default AXI channel and request/response types for cache_axi_txn_limiter.
// Real integrations override axi_req_t/axi_rsp_t with their own structs.
package cache_axi_txn_limiter_pkg;

  typedef struct packed {
    logic [31:0] xlen;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_ax_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } txn_axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } txn_axi_rsp_t;

endpackage

// File: rtl/cache_axi_txn_limiter.sv
// Outstanding-transaction limiter and quiesce handshake for the cache AXI port.
// All channels pass through combinationally; only AR/AW valid/ready are gated.
module cache_axi_txn_limiter #(
  parameter cache_axi_txn_limiter_pkg::cva6_cfg_t CVA6Cfg = cache_axi_txn_limiter_pkg::cva6_cfg_empty,
  parameter int unsigned MaxReadTxns  = 4,
  parameter int unsigned MaxWriteTxns = 4,
  parameter type axi_req_t = cache_axi_txn_limiter_pkg::txn_axi_req_t,
  parameter type axi_rsp_t = cache_axi_txn_limiter_pkg::txn_axi_rsp_t,
  localparam int unsigned RdW = $clog2(MaxReadTxns + 1),
  localparam int unsigned WrW = $clog2(MaxWriteTxns + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  axi_req_t       slv_req_i,
  output axi_rsp_t       slv_resp_o,
  output axi_req_t       mst_req_o,
  input  axi_rsp_t       mst_resp_i,
  input  logic           quiesce_i,
  output logic           quiesced_o,
  output logic           busy_o,
  output logic [RdW-1:0] rd_cnt_o,
  output logic [WrW-1:0] wr_cnt_o,
  output logic           err_o
);

  localparam logic [RdW-1:0] RdLimit = RdW'(MaxReadTxns);
  localparam logic [WrW-1:0] WrLimit = WrW'(MaxWriteTxns);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  state_e         state_q, state_d;
  logic [RdW-1:0] rd_cnt_q, rd_cnt_d;
  logic [WrW-1:0] wr_cnt_q, wr_cnt_d;
  logic           ar_pend_q, aw_pend_q;
  logic           err_q;
  logic           rd_uflow, wr_uflow;
  logic           ar_open, aw_open;
  logic           ar_hs, aw_hs, r_last_hs, b_hs;
  logic           idle;

  logic unused_cfg;
  assign unused_cfg = ^CVA6Cfg;

  // A request already on the bus keeps its gate open so valid never drops
  // before the handshake, even if the limit or quiesce would now block it.
  assign ar_open = ((rd_cnt_q < RdLimit) && (state_q == ST_RUN)) || ar_pend_q;
  assign aw_open = ((wr_cnt_q < WrLimit) && (state_q == ST_RUN)) || aw_pend_q;

  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = slv_req_i.ar_valid && ar_open;
    mst_req_o.aw_valid  = slv_req_i.aw_valid && aw_open;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready && ar_open;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready && aw_open;
  end

  assign ar_hs     = slv_req_i.ar_valid && ar_open && mst_resp_i.ar_ready;
  assign aw_hs     = slv_req_i.aw_valid && aw_open && mst_resp_i.aw_ready;
  assign r_last_hs = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
  assign b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    rd_uflow = 1'b0;
    unique case ({ar_hs, r_last_hs})
      2'b10: rd_cnt_d = rd_cnt_q + RdW'(1);
      2'b01: begin
        if (rd_cnt_q == '0) rd_uflow = 1'b1;
        else                rd_cnt_d = rd_cnt_q - RdW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wr_uflow = 1'b0;
    unique case ({aw_hs, b_hs})
      2'b10: wr_cnt_d = wr_cnt_q + WrW'(1);
      2'b01: begin
        if (wr_cnt_q == '0) wr_uflow = 1'b1;
        else                wr_cnt_d = wr_cnt_q - WrW'(1);
      end
      default: ;
    endcase
  end

  assign idle = (rd_cnt_q == '0) && (wr_cnt_q == '0) && !ar_pend_q && !aw_pend_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (quiesce_i) state_d = idle ? ST_HALTED : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!quiesce_i) state_d = ST_RUN;
        else if (idle)  state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (!quiesce_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      ar_pend_q <= 1'b0;
      aw_pend_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      ar_pend_q <= slv_req_i.ar_valid && ar_open && !mst_resp_i.ar_ready;
      aw_pend_q <= slv_req_i.aw_valid && aw_open && !mst_resp_i.aw_ready;
      err_q     <= err_q || rd_uflow || wr_uflow;
    end
  end

  assign quiesced_o = (state_q == ST_HALTED);
  assign busy_o     = !idle;
  assign rd_cnt_o   = rd_cnt_q;
  assign wr_cnt_o   = wr_cnt_q;
  assign err_o      = err_q;

endmodule
